// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : 14-bit binary to 4-digit BCD, serial double-dabble (14 clocks)
// Optional: BCD_LEADING_BLANK_EN replaces leading zero digits with BLANK_CODE
// Revision: 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic [3:0]  thousands
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [13:0] MAX_VAL  = 14'd9999;
  localparam logic [3:0]  LAST_CNT = 4'd13;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] scr_q, scr_d;
  logic        ovf_next_q, ovf_next_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic [15:0] dig_q, dig_d;

  logic [15:0] scr_adj;
  logic [15:0] scr_shift;
  logic [13:0] bin_shift;
  logic [15:0] dig_fmt;

  always_comb begin
    scr_adj = scr_q;
    for (int i = 0; i < 4; i++) begin
      if (scr_q[i*4 +: 4] >= 4'd5) begin
        scr_adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
      end
    end
    {scr_shift, bin_shift} = {scr_adj[14:0], bin_q, 1'b0};
  end

`ifdef BCD_LEADING_BLANK_EN
  // Blank from the top down, stopping at the first nonzero digit; ones always shown
  always_comb begin
    dig_fmt = scr_shift;
    if (scr_shift[15:12] == 4'd0) begin
      dig_fmt[15:12] = BLANK_CODE;
      if (scr_shift[11:8] == 4'd0) begin
        dig_fmt[11:8] = BLANK_CODE;
        if (scr_shift[7:4] == 4'd0) begin
          dig_fmt[7:4] = BLANK_CODE;
        end
      end
    end
  end
`else
  always_comb begin
    dig_fmt = scr_shift;
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    scr_d      = scr_q;
    ovf_next_d = ovf_next_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    dig_d      = dig_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = (bin > MAX_VAL) ? MAX_VAL : bin;
          ovf_next_d = (bin > MAX_VAL);
          scr_d      = 16'd0;
          cnt_d      = 4'd0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift;
        bin_d = bin_shift;
        if (cnt_q == LAST_CNT) begin
          // Digits and ovf commit together so the display only sees whole results
          dig_d   = dig_fmt;
          ovf_d   = ovf_next_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      bin_q      <= 14'd0;
      scr_q      <= 16'd0;
      ovf_next_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      dig_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      scr_q      <= scr_d;
      ovf_next_q <= ovf_next_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      dig_q      <= dig_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign thousands = dig_q[15:12];
  assign hundreds  = dig_q[11:8];
  assign tens      = dig_q[7:4];
  assign ones      = dig_q[3:0];

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// ============================================================================
// tb_bin2bcd_seq : directed self-checking bench for bin2bcd_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq;

`ifdef BCD_LEADING_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk;
  logic        clr;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  ones, tens, hundreds, thousands;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] exp_dig;
  logic        exp_ovf;

  bin2bcd_seq #(.BLANK_CODE(4'hF)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {thousands, hundreds, tens, ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at #1 after the accepting edge; runs to 1 cycle after done.
  // inject >= 0 pulses start with 5678 after that many SHIFT edges.
  task automatic finish_conv(input string tag, input logic [15:0] ep, input logic [15:0] eb,
                             input logic eo, input int inject, input bit drop_start);
    int n;
    int unstable;
    n = 0;
    unstable = 0;
    chk({tag, "_busy_after_accept"}, busy, 1);
    while (!done && n < 40) begin
      if (digits() !== exp_dig || ovf !== exp_ovf) unstable++;
      if (inject >= 0) begin
        start = (n == inject);
        bin   = (n == inject) ? 14'd5678 : 14'd0;
      end else if (drop_start) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 14);
    chk({tag, "_hold_during_conv"}, unstable, 0);
    exp_dig = BLANK ? eb : ep;
    exp_ovf = eo;
    chk({tag, "_digits"}, digits(), exp_dig);
    chk({tag, "_ovf"}, ovf, exp_ovf);
    chk({tag, "_busy_at_done"}, busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done_single"}, done, 0);
  endtask

  task automatic run_conv(input string tag, input logic [13:0] v, input logic [15:0] ep,
                          input logic [15:0] eb, input logic eo, input int inject);
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 14'h2AAA;
    finish_conv(tag, ep, eb, eo, inject, 1'b0);
  endtask

  initial begin
    int n;
    int saw_done;
    clr   = 1'b1;
    start = 1'b0;
    bin   = 14'd0;
    exp_dig = 16'h0000;
    exp_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_digits", digits(), 16'h0000);

    run_conv("c1234", 14'd1234, 16'h1234, 16'h1234, 1'b0, -1);
    run_conv("c0",    14'd0,    16'h0000, 16'hFFF0, 1'b0, -1);
    run_conv("c9999", 14'd9999, 16'h9999, 16'h9999, 1'b0, -1);
    run_conv("c305",  14'd305,  16'h0305, 16'hF305, 1'b0, -1);
    run_conv("c10000",14'd10000,16'h9999, 16'h9999, 1'b1, -1);
    run_conv("c16383",14'd16383,16'h9999, 16'h9999, 1'b1, -1);
    run_conv("c42",   14'd42,   16'h0042, 16'hFF42, 1'b0, -1);

    // start pulse during SHIFT must be ignored
    run_conv("ign",   14'd1234, 16'h1234, 16'h1234, 1'b0, 5);
    start = 1'b0;

    // start held high: back-to-back every 15 clocks
    start = 1'b1;
    bin   = 14'd7;
    @(posedge clk); #1;
    bin   = 14'd8;
    finish_conv("held7", 16'h0007, 16'hFFF7, 1'b0, -1, 1'b0);
    start = 1'b0;
    bin   = 14'd0;
    finish_conv("held8", 16'h0008, 16'hFFF8, 1'b0, -1, 1'b0);

    // clr during conversion aborts it
    start = 1'b1;
    bin   = 14'd9876;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_dig = 16'h0000;
    exp_ovf = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_digits", digits(), 16'h0000);
    chk("clr_ovf", ovf, 0);
    saw_done = 0;
    for (n = 0; n < 20; n++) begin
      if (done) saw_done++;
      @(posedge clk); #1;
    end
    chk("clr_no_done", saw_done, 0);
    chk("clr_digits_later", digits(), 16'h0000);

    run_conv("post_clr", 14'd305, 16'h0305, 16'hF305, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
